// File: rtl/dmem_pkg.sv
// Shared types and widths for the MEM-stage data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LAT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Operation captured at acceptance and replayed on the completion edge
  typedef struct packed {
    logic              rd;
    logic              wr;
    logic              mis;
    logic [WORD_W-1:0] wdata;
  } op_t;

endpackage

// File: rtl/dmem_responder_if.sv
// EX/MEM-facing request/response bundle of the data-memory responder.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              memRead_i;
  logic              memWrite_i;
  logic [WORD_W-1:0] addr_i;
  logic [WORD_W-1:0] wdata_i;
  logic [WORD_W-1:0] rdata_o;
  logic              stall_o;
  logic              ack_o;
  logic              err_o;

  modport master (
    output memRead_i, memWrite_i, addr_i, wdata_i,
    input  rdata_o, stall_o, ack_o, err_o
  );

  modport slave (
    input  memRead_i, memWrite_i, addr_i, wdata_i,
    output rdata_o, stall_o, ack_o, err_o
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered, read-before-write output port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic                           we_i,
  input  logic                           re_i,
  input  logic                           clr_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
  input  logic [WORD_W-1:0]              wdata_i,
  output logic [WORD_W-1:0]              rdata_o
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Contents survive reset
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem[idx_i] <= wdata_i;
    end
  end

  // Output holds unless a read or a clear completes on this edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o <= '0;
    end else if (en_i && clr_i) begin
      rdata_o <= '0;
    end else if (en_i && re_i) begin
      rdata_o <= mem[idx_i];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: stalls the pipeline for LATENCY wait cycles, then acks.
// Optional misaligned-access detection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_e            state;
  logic [LAT_W-1:0]  cnt;
  op_t               op_q;
  logic [IDX_W-1:0]  idx_q;
  logic              ack_q;
  logic              req;
  logic              mis;
  logic              fire;
  logic [WORD_W-1:0] rdata;
  logic              unused_addr_bits;

  assign req  = bus.memRead_i | bus.memWrite_i;
  assign fire = (state == WAIT) && (cnt == '0) && !rst_i;

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = |bus.addr_i[1:0];
`else
  assign mis = 1'b0;
`endif

  // Byte offset and bits above the array size never select a word
  assign unused_addr_bits = ^{bus.addr_i[WORD_W-1:IDX_W+2], bus.addr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      idx_q <= '0;
      ack_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state <= WAIT;
            cnt   <= LAT_W'(LATENCY - 1);
            op_q  <= '{rd: bus.memRead_i, wr: bus.memWrite_i, mis: mis, wdata: bus.wdata_i};
            idx_q <= bus.addr_i[IDX_W+1:2];
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - LAT_W'(1);
          end else begin
            state <= RESP;
            ack_q <= 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;

  // Error pulse coincides with the ack of a misaligned access
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= fire && op_q.mis;
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (fire),
    .we_i    (op_q.wr && !op_q.mis),
    .re_i    (op_q.rd && !op_q.mis),
    .clr_i   (op_q.mis),
    .idx_i   (idx_q),
    .wdata_i (op_q.wdata),
    .rdata_o (rdata)
  );

  assign bus.rdata_o = rdata;
  assign bus.stall_o = ((state == IDLE) && req) || (state == WAIT);
  assign bus.ack_o   = ack_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a cycle-timeline reference model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 1'b0;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: request accepted at cycle t0 stalls through t0+LAT and acks at t0+LAT+1
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata;
  bit          busy = 1'b0;
  int          cyc  = 0;
  int          t0   = 0;
  bit          o_rd, o_wr, o_mis;
  logic [31:0] o_wd;
  int          o_idx;

  function automatic bit misaligned(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      m_rdata <= 32'h0;
    end else if (!busy) begin
      if (bus.memRead_i || bus.memWrite_i) begin
        busy  <= 1'b1;
        t0    <= cyc;
        o_rd  <= bus.memRead_i;
        o_wr  <= bus.memWrite_i;
        o_mis <= misaligned(bus.addr_i);
        o_wd  <= bus.wdata_i;
        o_idx <= int'((bus.addr_i >> 2) % 32'(DEPTH));
      end
    end else begin
      if (cyc == t0 + LAT) begin
        if (o_mis) begin
          m_rdata <= 32'h0;
        end else begin
          if (o_rd) m_rdata <= m_mem[o_idx];
          if (o_wr) m_mem[o_idx] <= o_wd;
        end
      end
      if (cyc == t0 + LAT + 1) busy <= 1'b0;
    end
    cyc <= cyc + 1;
  end

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin : cmp
    bit e_stall;
    bit e_ack;
    if (chk_en) begin
      e_stall = busy ? (cyc <= t0 + LAT) : (bus.memRead_i || bus.memWrite_i);
      e_ack   = busy && (cyc == t0 + LAT + 1);
      chk1("stall", bus.stall_o, e_stall);
      chk1("ack", bus.ack_o, e_ack);
      chk1("err", bus.err_o, e_ack && o_mis);
      chk32("rdata", bus.rdata_o, m_rdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    bus.memRead_i  = rd;
    bus.memWrite_i = wr;
    bus.addr_i     = a;
    bus.wdata_i    = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, $urandom, $urandom);
  endtask

  // Issue one access; inputs are scrambled after acceptance to prove they are ignored
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] got, output int lat, output logic err);
    lat = -1;
    got = 32'h0;
    err = 1'b0;
    drive(rd, wr, a, wd);
    for (int k = 0; k <= LAT + 4; k++) begin
      @(negedge clk);
      if (bus.ack_o) begin
        lat = k;
        got = bus.rdata_o;
        err = bus.err_o;
        break;
      end
      step();
      if (k + 1 <= LAT + 1) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      else idle();
    end
    step();
    idle();
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL access_timeout addr=%08h got=no_ack exp=ack", a);
    end
  endtask

  task automatic pinned(input string name, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] got;
    int          lat;
    logic        err;
    access(rd, wr, a, wd, got, lat, err);
    chki({name, "_lat"}, lat, 3);
    chk32({name, "_rdata"}, got, exp_rdata);
    chk1({name, "_err"}, err, exp_err);
  endtask

  // Start an access, then reset k cycles after acceptance
  task automatic reset_during(input int k);
    drive(1'($urandom_range(0, 1)), 1'b1, $urandom, $urandom);
    for (int j = 1; j <= k; j++) begin
      step();
      if (j == k) begin
        rst = 1'b1;
        idle();
      end else begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
    end
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] got;
    int          lat;
    logic        err;
    int          op;

    rst = 1'b1;
    idle();
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk32("reset_rdata", bus.rdata_o, 32'h0);
    chk1("reset_ack", bus.ack_o, 1'b0);
    chk1("reset_err", bus.err_o, 1'b0);
    chk1("reset_stall", bus.stall_o, 1'b0);
    step();

    for (int i = 0; i < DEPTH; i++) begin
      access(1'b0, 1'b1, 32'(i * 4), $urandom, got, lat, err);
    end

    pinned("wr_10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    pinned("rd_10", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    pinned("wr_400", 1'b0, 1'b1, 32'h400, 32'h1, 32'hDEADBEEF, 1'b0);
    pinned("rd_wrap0", 1'b1, 1'b0, 32'h0, 32'h0, 32'h1, 1'b0);
    pinned("rw_10", 1'b1, 1'b1, 32'h10, 32'h5, 32'hDEADBEEF, 1'b0);
    pinned("rd_10_new", 1'b1, 1'b0, 32'h10, 32'h0, 32'h5, 1'b0);
    pinned("wr_20", 1'b0, 1'b1, 32'h20, 32'h12345678, 32'h5, 1'b0);

    // Abandon a write to 0x20 by resetting in its first wait cycle
    drive(1'b0, 1'b1, 32'h20, 32'h77);
    step();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk1("abort_stall", bus.stall_o, 1'b0);
    chk1("abort_ack", bus.ack_o, 1'b0);
    chk32("abort_rdata", bus.rdata_o, 32'h0);
    step();
    repeat (3) step();
    pinned("rd_20_old", 1'b1, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
    pinned("rd_13", 1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
`else
    pinned("rd_13", 1'b1, 1'b0, 32'h13, 32'h0, 32'h5, 1'b0);
`endif

    for (int n = 0; n < 400; n++) begin
      if (n % 25 == 24) begin
        reset_during($urandom_range(1, LAT + 1));
      end else begin
        op = $urandom_range(0, 2);
        access(op != 1, op != 0, $urandom, $urandom, got, lat, err);
      end
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (4) step();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the five-stage pipeline's MEM stage. It accepts the read and write strobes, the ALU-computed address and the store data produced by EX/MEM. It serves each access from an internal word array after a fixed, parameterised wait. While the access is outstanding it freezes the pipeline through `stall_o`, then returns load data with a one-cycle `ack_o` so MEM/WB can latch it.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: number of 32-bit words; power of two, 16..4096.
- `LATENCY`, default 2: number of WAIT cycles per access; legal range 1..15.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `memRead_i`  in  1  load request from EX/MEM.
- `memWrite_i`  in  1  store request from EX/MEM.
- `addr_i`  in  32  byte address (ALU result).
- `wdata_i`  in  32  store data.
- `rdata_o`  out  32  load data, registered.
- `stall_o`  out  1  pipeline freeze (PC, IF/ID, ID/EX, EX/MEM hold).
- `ack_o`  out  1  one-cycle pulse when the access completes.
- `err_o`  out  1  misaligned-access flag; driven only when the configuration macro below is defined.

## Operation
- FSM states:
  - IDLE: no access outstanding.
  - WAIT: access in flight; a 4-bit counter `cnt` tracks remaining wait cycles.
  - RESP: access complete; ack cycle.
- A request is `req = memRead_i | memWrite_i`.
- Transitions:
  - IDLE & req: capture the address, write data and operation; load `cnt = LATENCY-1`; go to WAIT.
  - IDLE & !req: stay in IDLE.
  - WAIT & `cnt != 0`: decrement `cnt`.
  - WAIT & `cnt == 0`: perform the array access on this edge; go to RESP.
  - RESP: go to IDLE unconditionally. A request present during RESP is not accepted.
- `stall_o = (IDLE & req) | WAIT`. This is combinational, so it is asserted in the same cycle the request first appears. It is low in RESP.
- `ack_o` is high exactly when the state is RESP.
- Word index is `addr_i[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo the array size.
- Read completion: `rdata_o` is loaded with the addressed word.
- Write completion: the word is written and `rdata_o` keeps its previous value.
- Read and write requested together: the write is performed, and `rdata_o` is loaded with the word as it was before the write (read-before-write).
- The array contents are not cleared by reset.

## Timing
- Request first seen in cycle 0. `stall_o` is high for cycles 0..LATENCY. `ack_o` and valid `rdata_o` occur in cycle LATENCY+1. The next request can be accepted in cycle LATENCY+2.
- Reset values:
  - state = IDLE, `cnt` = 0.
  - `rdata_o` = 0, `ack_o` = 0, `err_o` = 0.
  - `stall_o` follows its combinational equation.
- Reset asserted mid-access: the access is abandoned. A pending write that has not reached its completion edge is not performed, and no ack is produced.
- The request inputs are sampled only in IDLE. Changes to them during WAIT are ignored.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - At acceptance, `addr_i[1:0] != 0` marks the access misaligned.
  - The access still runs the full WAIT/RESP timing.
  - No write is performed, and `rdata_o` is loaded with 0.
  - `err_o` pulses in the same cycle as `ack_o`.
- `DMEM_ALIGN_CHECK_EN` undefined:
  - `addr_i[1:0]` is ignored.
  - `err_o` is tied to 0.

## Structure
- Package `dmem_pkg` holds:
  - the state enum (IDLE, WAIT, RESP);
  - `WORD_W = 32`;
  - `LAT_W = 4`.
- Sub-module `dmem_array`: single-port synchronous word RAM with write enable and registered read-before-write output. The responder FSM drives its enable only on the WAIT→RESP edge.

## Test plan
- Reset with LATENCY=2, then write 0xDEADBEEF to 0x10 in cycle 0. Expect `stall_o` high in cycles 0–2, `ack_o` high in cycle 3 only, and `rdata_o` still 0.
- Read 0x10. Expect `rdata_o` = 0xDEADBEEF with `ack_o` in cycle 3, and `stall_o` low in cycle 3.
- With DEPTH_WORDS=256, write 0x00000001 to 0x400, then read 0x0. Expect 0x00000001 (address wrap).
- Assert read and write together on 0x10 with data 0x5. Expect `rdata_o` = 0xDEADBEEF; a following read of 0x10 returns 0x5.
- Start a write of 0x77 to 0x20, then assert `rst_i` in the first WAIT cycle. Expect state IDLE and `stall_o` = 0 on the next cycle, no `ack_o`, and a later read of 0x20 returning its old value.
- With `DMEM_ALIGN_CHECK_EN` defined, read 0x13. Expect `err_o` and `ack_o` together in cycle LATENCY+1 and `rdata_o` = 0. With the macro undefined, the same read returns the word at 0x10.
